// File: rtl/mac_4bit_dot_seq.sv
// mac_4bit_dot_seq: dot-product job sequencer driving the 4-bit MAC pins.
// Define MAC_4BIT_DOT_SEQ_ZERO_SKIP_EN to suppress CLK_EN on zero non-first terms.
module mac_4bit_dot_seq #(
  parameter int LEN_WIDTH = 6
) (
  input  logic                 MAC_ACC_CLK,
  input  logic                 MAC_ACC_RST,
  input  logic                 START,
  input  logic [LEN_WIDTH-1:0] CFG_LEN,
  input  logic [5:0]           CFG_OUT_SEL,
  input  logic                 CFG_RND,
  input  logic                 CFG_SAT,
  input  logic                 CFG_TC,
  output logic                 BUSY,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [3:0]           IN_OPER,
  input  logic [3:0]           IN_COEF,
  output logic [3:0]           MAC_OPER_DATA,
  output logic [3:0]           MAC_COEF_DATA,
  output logic                 EFPGA_MATHB_CLK_EN,
  output logic                 MAC_ACC_CLEAR,
  output logic                 MAC_ACC_RND,
  output logic                 MAC_ACC_SAT,
  output logic [5:0]           MAC_OUT_SEL,
  output logic                 MAC_TC,
  input  logic [3:0]           MAC_OUT,
  output logic                 RES_VALID,
  input  logic                 RES_READY,
  output logic [3:0]           RES_DATA
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RUN    = 3'd1;
  localparam logic [2:0] S_DRAIN  = 3'd2;
  localparam logic [2:0] S_CAPT   = 3'd3;
  localparam logic [2:0] S_RESULT = 3'd4;

  logic [2:0]           state;
  logic [LEN_WIDTH-1:0] cnt;
  logic                 first;
  logic                 cfg_rnd;

  logic start_acc;
  logic in_hs;
  logic last_term;
  logic issue;
  logic res_hs;
  logic [LEN_WIDTH-1:0] len_load;

  assign start_acc = (state == S_IDLE) & START;
  assign in_hs     = (state == S_RUN) & IN_VALID & IN_READY;
  assign last_term = (cnt == LEN_WIDTH'(1));
  assign res_hs    = (state == S_RESULT) & RES_READY;
  assign len_load  = (CFG_LEN == '0) ? LEN_WIDTH'(1) : CFG_LEN;

`ifdef MAC_4BIT_DOT_SEQ_ZERO_SKIP_EN
  // zero products add nothing; the first term still clears/rounds
  assign issue = first | ((IN_OPER != 4'd0) & (IN_COEF != 4'd0));
`else
  assign issue = 1'b1;
`endif

  // Job FSM: state, remaining-term counter, first-term flag, handshake flags
  always_ff @(posedge MAC_ACC_CLK) begin
    if (MAC_ACC_RST) begin
      state    <= S_IDLE;
      cnt      <= '0;
      first    <= 1'b0;
      cfg_rnd  <= 1'b0;
      BUSY     <= 1'b0;
      IN_READY <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (START) begin
            cnt      <= len_load;
            first    <= 1'b1;
            cfg_rnd  <= CFG_RND;
            BUSY     <= 1'b1;
            IN_READY <= 1'b1;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          if (in_hs) begin
            cnt   <= cnt - LEN_WIDTH'(1);
            first <= 1'b0;
            if (last_term) begin
              IN_READY <= 1'b0;
              state    <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          state <= S_CAPT;
        end
        S_CAPT: begin
          state <= S_RESULT;
        end
        S_RESULT: begin
          if (RES_READY) begin
            BUSY  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          state    <= S_IDLE;
          BUSY     <= 1'b0;
          IN_READY <= 1'b0;
        end
      endcase
    end
  end

  // MAC pin drive: one-cycle accumulate strobes, operands, latched config
  always_ff @(posedge MAC_ACC_CLK) begin
    if (MAC_ACC_RST) begin
      MAC_OPER_DATA      <= 4'd0;
      MAC_COEF_DATA      <= 4'd0;
      EFPGA_MATHB_CLK_EN <= 1'b0;
      MAC_ACC_CLEAR      <= 1'b0;
      MAC_ACC_RND        <= 1'b0;
      MAC_ACC_SAT        <= 1'b0;
      MAC_OUT_SEL        <= 6'd0;
      MAC_TC             <= 1'b0;
    end else begin
      EFPGA_MATHB_CLK_EN <= 1'b0;
      MAC_ACC_CLEAR      <= 1'b0;
      MAC_ACC_RND        <= 1'b0;
      if (start_acc) begin
        MAC_ACC_SAT <= CFG_SAT;
        MAC_OUT_SEL <= CFG_OUT_SEL;
        MAC_TC      <= CFG_TC;
      end
      if (in_hs) begin
        MAC_OPER_DATA      <= IN_OPER;
        MAC_COEF_DATA      <= IN_COEF;
        EFPGA_MATHB_CLK_EN <= issue;
        MAC_ACC_CLEAR      <= first & ~cfg_rnd;
        MAC_ACC_RND        <= first & cfg_rnd;
      end
    end
  end

  // Result port: capture MAC_OUT once the last term has settled
  always_ff @(posedge MAC_ACC_CLK) begin
    if (MAC_ACC_RST) begin
      RES_DATA  <= 4'd0;
      RES_VALID <= 1'b0;
    end else begin
      if (state == S_CAPT) begin
        RES_DATA  <= MAC_OUT;
        RES_VALID <= 1'b1;
      end else if (res_hs) begin
        RES_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_4bit_dot_seq.sv
// tb_mac_4bit_dot_seq: scoreboard bench with a behavioural 20-bit MAC model.
// Expected results come from an integer dot-product reference.
module tb_mac_4bit_dot_seq;

  logic       MAC_ACC_CLK = 1'b0;
  logic       MAC_ACC_RST;
  logic       START;
  logic [5:0] CFG_LEN;
  logic [5:0] CFG_OUT_SEL;
  logic       CFG_RND, CFG_SAT, CFG_TC;
  logic       BUSY;
  logic       IN_VALID, IN_READY;
  logic [3:0] IN_OPER, IN_COEF;
  logic [3:0] MAC_OPER_DATA, MAC_COEF_DATA;
  logic       EFPGA_MATHB_CLK_EN, MAC_ACC_CLEAR, MAC_ACC_RND;
  logic       MAC_ACC_SAT, MAC_TC;
  logic [5:0] MAC_OUT_SEL;
  logic [3:0] MAC_OUT;
  logic       RES_VALID, RES_READY;
  logic [3:0] RES_DATA;

  always #5 MAC_ACC_CLK = ~MAC_ACC_CLK;

  mac_4bit_dot_seq #(.LEN_WIDTH(6)) dut (
    .MAC_ACC_CLK(MAC_ACC_CLK), .MAC_ACC_RST(MAC_ACC_RST),
    .START(START), .CFG_LEN(CFG_LEN), .CFG_OUT_SEL(CFG_OUT_SEL),
    .CFG_RND(CFG_RND), .CFG_SAT(CFG_SAT), .CFG_TC(CFG_TC),
    .BUSY(BUSY), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_OPER(IN_OPER), .IN_COEF(IN_COEF),
    .MAC_OPER_DATA(MAC_OPER_DATA), .MAC_COEF_DATA(MAC_COEF_DATA),
    .EFPGA_MATHB_CLK_EN(EFPGA_MATHB_CLK_EN),
    .MAC_ACC_CLEAR(MAC_ACC_CLEAR), .MAC_ACC_RND(MAC_ACC_RND),
    .MAC_ACC_SAT(MAC_ACC_SAT), .MAC_OUT_SEL(MAC_OUT_SEL),
    .MAC_TC(MAC_TC), .MAC_OUT(MAC_OUT),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA)
  );

  // behavioural MAC: 20-bit accumulator, shift/round/saturate on output
  logic [19:0]        m_acc = 20'd0;
  logic [19:0]        m_ea, m_eb, m_prod, m_rc;
  logic signed [20:0] m_sh;

  always_comb begin
    m_ea = MAC_TC ? {{16{MAC_OPER_DATA[3]}}, MAC_OPER_DATA}
                  : {16'd0, MAC_OPER_DATA};
    m_eb = MAC_TC ? {{16{MAC_COEF_DATA[3]}}, MAC_COEF_DATA}
                  : {16'd0, MAC_COEF_DATA};
    m_prod = m_ea * m_eb;
    m_rc = (MAC_OUT_SEL == 6'd0) ? 20'd0 : (20'd1 << (MAC_OUT_SEL - 6'd1));
  end

  always @(posedge MAC_ACC_CLK) begin
    if (EFPGA_MATHB_CLK_EN) begin
      if (MAC_ACC_CLEAR)    m_acc <= m_prod;
      else if (MAC_ACC_RND) m_acc <= m_rc + m_prod;
      else                  m_acc <= m_acc + m_prod;
    end
  end

  always_comb begin
    if (MAC_TC) m_sh = $signed({m_acc[19], m_acc}) >>> MAC_OUT_SEL;
    else        m_sh = $signed({1'b0, m_acc}) >>> MAC_OUT_SEL;
    MAC_OUT = m_sh[3:0];
    if (MAC_ACC_SAT) begin
      if (MAC_TC) begin
        if (m_sh > 7)       MAC_OUT = 4'h7;
        else if (m_sh < -8) MAC_OUT = 4'h8;
      end else if (m_sh > 15) begin
        MAC_OUT = 4'hF;
      end
    end
  end

  // pin activity counters, sampled on the edge that consumes each cycle
  int mon_en = 0, mon_clr = 0, mon_rnd = 0, mon_viol = 0;
  always @(posedge MAC_ACC_CLK) begin
    if (EFPGA_MATHB_CLK_EN) mon_en++;
    if (MAC_ACC_CLEAR) mon_clr++;
    if (MAC_ACC_RND) mon_rnd++;
    if ((MAC_ACC_CLEAR | MAC_ACC_RND) & ~EFPGA_MATHB_CLK_EN) mon_viol++;
  end

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] exp_q[$];
  logic [3:0] p_op[16];
  logic [3:0] p_cf[16];

  function automatic logic [3:0] ref_res(int n, bit tc, bit sat,
                                         int sel, bit rnd);
    longint acc = 0;
    longint a, b, sh;
    logic [3:0] r;
    for (int i = 0; i < n; i++) begin
      a = tc ? longint'($signed(p_op[i])) : longint'(p_op[i]);
      b = tc ? longint'($signed(p_cf[i])) : longint'(p_cf[i]);
      acc += a * b;
    end
    if (rnd && sel > 0) acc += longint'(1) << (sel - 1);
    sh = acc >>> sel;
    if (sat && tc && sh > 7) sh = 7;
    if (sat && tc && sh < -8) sh = -8;
    if (sat && !tc && sh > 15) sh = 15;
    r = sh[3:0];
    return r;
  endfunction

  // runs one job from the current negedge; returns observations
  task automatic run_job(input int len, input int sel, input bit rnd,
                         input bit sat, input bit tc, input int np,
                         input bit gaps, input int hold,
                         output logic [3:0] got, output logic [3:0] exp,
                         output int pulses, output int clrs,
                         output int rnds, output int lat,
                         output bit to, output bit unstable);
    int e0, c0, r0, w;
    exp_q.push_back(ref_res(np, tc, sat, sel, rnd));
    to = 1'b0;
    unstable = 1'b0;
    e0 = mon_en; c0 = mon_clr; r0 = mon_rnd;
    START = 1'b1;
    CFG_LEN = 6'(len);
    CFG_OUT_SEL = 6'(sel);
    CFG_RND = rnd; CFG_SAT = sat; CFG_TC = tc;
    @(negedge MAC_ACC_CLK);
    START = 1'b0;
    for (int i = 0; i < np; i++) begin
      if (gaps && (i % 2 == 1)) begin
        IN_VALID = 1'b0;
        @(negedge MAC_ACC_CLK);
      end
      IN_VALID = 1'b1;
      IN_OPER = p_op[i];
      IN_COEF = p_cf[i];
      w = 0;
      while (!IN_READY && w < 20) begin
        @(negedge MAC_ACC_CLK);
        w++;
      end
      if (!IN_READY) to = 1'b1;
      @(negedge MAC_ACC_CLK);
    end
    IN_VALID = 1'b0;
    lat = 1;
    while (!RES_VALID && lat < 40) begin
      @(negedge MAC_ACC_CLK);
      lat++;
    end
    if (!RES_VALID) to = 1'b1;
    got = RES_DATA;
    exp = exp_q.pop_front();
    for (int h = 0; h < hold; h++) begin
      START = 1'b1;
      @(negedge MAC_ACC_CLK);
      if (RES_VALID !== 1'b1 || RES_DATA !== got || BUSY !== 1'b1)
        unstable = 1'b1;
    end
    START = 1'b0;
    RES_READY = 1'b1;
    @(negedge MAC_ACC_CLK);
    RES_READY = 1'b0;
    pulses = mon_en - e0;
    clrs = mon_clr - c0;
    rnds = mon_rnd - r0;
  endtask

  logic [3:0] got, exp;
  int pulses, clrs, rnds, lat;
  bit to, unst;

  task automatic test_reset();
    MAC_ACC_RST = 1'b1;
    START = 0; CFG_LEN = 0; CFG_OUT_SEL = 0;
    CFG_RND = 0; CFG_SAT = 0; CFG_TC = 0;
    IN_VALID = 0; IN_OPER = 0; IN_COEF = 0; RES_READY = 0;
    repeat (3) @(negedge MAC_ACC_CLK);
    n_vec++;
    if ({BUSY, IN_READY, MAC_OPER_DATA, MAC_COEF_DATA, EFPGA_MATHB_CLK_EN,
         MAC_ACC_CLEAR, MAC_ACC_RND, MAC_ACC_SAT, MAC_OUT_SEL, MAC_TC,
         RES_VALID, RES_DATA} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: outputs not all zero");
    end
    MAC_ACC_RST = 1'b0;
    @(negedge MAC_ACC_CLK);
  endtask

  task automatic test_unsigned();
    p_op[0] = 2; p_cf[0] = 3;
    p_op[1] = 1; p_cf[1] = 4;
    p_op[2] = 3; p_cf[2] = 1;
    run_job(3, 0, 0, 0, 0, 3, 0, 0, got, exp, pulses, clrs, rnds, lat, to, unst);
    n_vec++;
    if (to || got !== exp || exp !== 4'hD) begin
      n_err++;
      $display("FAIL unsigned_res: got %h expected %h to=%0d", got, exp, to);
    end
    n_vec++;
    if (pulses !== 3 || clrs !== 1 || rnds !== 0 || mon_viol !== 0) begin
      n_err++;
      $display("FAIL unsigned_pins: en=%0d clr=%0d rnd=%0d viol=%0d need 3/1/0/0",
               pulses, clrs, rnds, mon_viol);
    end
    n_vec++;
    if (lat !== 3) begin
      n_err++;
      $display("FAIL unsigned_latency: got %0d expected 3", lat);
    end
  endtask

  task automatic test_signed();
    p_op[0] = 7; p_cf[0] = 7;
    p_op[1] = 7; p_cf[1] = 7;
    run_job(2, 0, 0, 1, 1, 2, 0, 0, got, exp, pulses, clrs, rnds, lat, to, unst);
    n_vec++;
    if (to || got !== exp || got !== 4'h7) begin
      n_err++;
      $display("FAIL signed_pos_sat: got %h expected 7", got);
    end
    p_op[0] = 8; p_cf[0] = 7;
    run_job(1, 0, 0, 1, 1, 1, 0, 0, got, exp, pulses, clrs, rnds, lat, to, unst);
    n_vec++;
    if (to || got !== exp || got !== 4'h8) begin
      n_err++;
      $display("FAIL signed_neg_sat: got %h expected 8", got);
    end
  endtask

  task automatic test_round();
    p_op[0] = 3; p_cf[0] = 2;
    run_job(1, 2, 0, 0, 0, 1, 0, 0, got, exp, pulses, clrs, rnds, lat, to, unst);
    n_vec++;
    if (to || got !== exp || got !== 4'h1) begin
      n_err++;
      $display("FAIL round_off: got %h expected 1", got);
    end
    run_job(1, 2, 1, 0, 0, 1, 0, 0, got, exp, pulses, clrs, rnds, lat, to, unst);
    n_vec++;
    if (to || got !== exp || got !== 4'h2) begin
      n_err++;
      $display("FAIL round_on: got %h expected 2", got);
    end
    n_vec++;
    if (rnds !== 1 || clrs !== 0 || pulses !== 1) begin
      n_err++;
      $display("FAIL round_pins: rnd=%0d clr=%0d en=%0d need 1/0/1",
               rnds, clrs, pulses);
    end
    n_vec++;
    if (MAC_OUT_SEL !== 6'd2) begin
      n_err++;
      $display("FAIL cfg_hold: MAC_OUT_SEL %0d expected 2", MAC_OUT_SEL);
    end
  endtask

  task automatic test_len0_hold();
    p_op[0] = 4; p_cf[0] = 3;
    run_job(0, 0, 0, 0, 0, 1, 0, 5, got, exp, pulses, clrs, rnds, lat, to, unst);
    n_vec++;
    if (to || got !== exp || got !== 4'hC || pulses !== 1) begin
      n_err++;
      $display("FAIL len0: got %h en=%0d expected c/1", got, pulses);
    end
    n_vec++;
    if (unst) begin
      n_err++;
      $display("FAIL result_hold: result changed while RES_READY low");
    end
    @(negedge MAC_ACC_CLK);
    n_vec++;
    if (BUSY !== 1'b0 || IN_READY !== 1'b0 || RES_VALID !== 1'b0) begin
      n_err++;
      $display("FAIL start_in_result: busy=%b rdy=%b vld=%b need 000",
               BUSY, IN_READY, RES_VALID);
    end
  endtask

  task automatic test_reset_mid();
    START = 1'b1; CFG_LEN = 6'd4; CFG_OUT_SEL = 6'd0;
    CFG_RND = 0; CFG_SAT = 0; CFG_TC = 0;
    @(negedge MAC_ACC_CLK);
    START = 1'b0;
    IN_VALID = 1'b1; IN_OPER = 4'd1; IN_COEF = 4'd1;
    @(negedge MAC_ACC_CLK);
    IN_OPER = 4'd2;
    @(negedge MAC_ACC_CLK);
    IN_VALID = 1'b0;
    MAC_ACC_RST = 1'b1;
    @(negedge MAC_ACC_CLK);
    n_vec++;
    if ({BUSY, IN_READY, MAC_OPER_DATA, MAC_COEF_DATA, EFPGA_MATHB_CLK_EN,
         MAC_ACC_CLEAR, MAC_ACC_RND, MAC_ACC_SAT, MAC_OUT_SEL, MAC_TC,
         RES_VALID, RES_DATA} !== '0) begin
      n_err++;
      $display("FAIL reset_mid: outputs not all zero after reset");
    end
    MAC_ACC_RST = 1'b0;
    @(negedge MAC_ACC_CLK);
    p_op[0] = 5; p_cf[0] = 1;
    run_job(1, 0, 0, 0, 0, 1, 0, 0, got, exp, pulses, clrs, rnds, lat, to, unst);
    n_vec++;
    if (to || got !== exp || got !== 4'h5) begin
      n_err++;
      $display("FAIL after_reset_job: got %h expected 5", got);
    end
  endtask

  task automatic test_zero_skip();
    int exp_p;
`ifdef MAC_4BIT_DOT_SEQ_ZERO_SKIP_EN
    exp_p = 2;
`else
    exp_p = 4;
`endif
    p_op[0] = 1; p_cf[0] = 1;
    p_op[1] = 0; p_cf[1] = 9;
    p_op[2] = 3; p_cf[2] = 0;
    p_op[3] = 2; p_cf[3] = 2;
    run_job(4, 0, 0, 0, 0, 4, 0, 0, got, exp, pulses, clrs, rnds, lat, to, unst);
    n_vec++;
    if (to || got !== exp || got !== 4'h5) begin
      n_err++;
      $display("FAIL zero_skip_res: got %h expected 5", got);
    end
    n_vec++;
    if (pulses !== exp_p) begin
      n_err++;
      $display("FAIL zero_skip_pulses: got %0d expected %0d", pulses, exp_p);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      p_op[i] = 4'($urandom_range(0, 3));
      p_cf[i] = 4'($urandom_range(0, 3));
    end
    run_job(4, 0, 0, 0, 0, 4, 0, 0, got, exp, pulses, clrs, rnds, lat, to, unst);
    n_vec++;
    if (to || got !== exp || lat !== 3) begin
      n_err++;
      $display("FAIL b2b_job1: got %h expected %h lat %0d", got, exp, lat);
    end
    n_vec++;
    if (BUSY !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_busy: got %b expected 0", BUSY);
    end
    for (int i = 0; i < 6; i++) begin
      p_op[i] = 4'($urandom_range(0, 15));
      p_cf[i] = 4'($urandom_range(0, 15));
    end
    run_job(6, 1, 0, 1, 1, 6, 1, 0, got, exp, pulses, clrs, rnds, lat, to, unst);
    n_vec++;
    if (to || got !== exp || pulses !== 6 || lat !== 3) begin
      n_err++;
      $display("FAIL b2b_job2: got %h expected %h en=%0d lat=%0d",
               got, exp, pulses, lat);
    end
    n_vec++;
    if (mon_viol !== 0) begin
      n_err++;
      $display("FAIL strobe_gating: %0d clear/rnd without en", mon_viol);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_round();
    test_len0_hold();
    test_reset_mid();
    test_zero_skip();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
